// File: rtl/wb_trace_collector.sv
// wb_trace_collector: in-order FIFO of core GRF/DM write events presented as valid/ready trace records
// Ports: clk, reset (async active-low); grf_we/pc/addr/wdata (WB writes);
// dm_we/pc/addr/wdata (MEM stores); out_valid/out_ready/out_kind/out_pc/out_addr/out_data
// (head record); count/full/overflow (status). Optional macro TRACE_TS_EN adds out_time.
module wb_trace_collector #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              grf_we,
  input  logic [31:0]       grf_pc,
  input  logic [4:0]        grf_addr,
  input  logic [31:0]       grf_wdata,
  input  logic              dm_we,
  input  logic [31:0]       dm_pc,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_kind,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_addr,
  output logic [31:0]       out_data,
`ifdef TRACE_TS_EN
  output logic [31:0]       out_time,
`endif
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow
);
`ifdef TRACE_TS_EN
  localparam int EW = 129;
  logic [31:0] ts;
  always_ff @(posedge clk or negedge reset)
    if (!reset) ts <= '0;
    else ts <= ts + 32'd1;
`else
  localparam int EW = 97;
`endif
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_M1 = (ADDR_W+1)'(DEPTH - 1);
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] g_ent, d_ent, head;
  logic [ADDR_W-1:0] wptr, rptr, dptr;
  logic gq, dq, push_g, push_d, pop, drop;
`ifdef TRACE_TS_EN
  assign g_ent = {1'b0, grf_pc, 27'b0, grf_addr, grf_wdata, ts};
  assign d_ent = {1'b1, dm_pc, dm_addr, dm_wdata, ts};
  assign {out_kind, out_pc, out_addr, out_data, out_time} = head;
`else
  assign g_ent = {1'b0, grf_pc, 27'b0, grf_addr, grf_wdata};
  assign d_ent = {1'b1, dm_pc, dm_addr, dm_wdata};
  assign {out_kind, out_pc, out_addr, out_data} = head;
`endif
  assign gq = grf_we && (grf_addr != 5'd0);
  assign dq = dm_we;
  // space is judged on start-of-cycle occupancy; a same-cycle pop never frees a slot
  assign push_g = gq && (count != DEPTH_C);
  assign push_d = dq && (gq ? (count < DEPTH_M1) : (count != DEPTH_C));
  assign drop = (gq && !push_g) || (dq && !push_d);
  assign out_valid = (count != '0);
  assign pop = out_valid && out_ready;
  assign full = (count == DEPTH_C);
  assign dptr = wptr + ADDR_W'(push_g);
  // gating on out_valid keeps stale storage off the port while empty or in reset
  assign head = out_valid ? mem[rptr] : '0;
  always_ff @(posedge clk) begin
    if (push_g) mem[wptr] <= g_ent;
    if (push_d) mem[dptr] <= d_ent;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      wptr <= dptr + ADDR_W'(push_d);
      rptr <= rptr + ADDR_W'(pop);
      count <= count + (ADDR_W+1)'(push_g) + (ADDR_W+1)'(push_d) - (ADDR_W+1)'(pop);
      overflow <= overflow | drop;
    end
endmodule

// File: tb/tb_wb_trace_collector.sv
// tb_wb_trace_collector: randomized and directed check of wb_trace_collector against a queue model
module tb_wb_trace_collector;
  localparam int DEPTH = 8;
  logic clk = 0, reset = 0;
  logic grf_we = 0, dm_we = 0, out_ready = 0;
  logic [31:0] grf_pc = 0, grf_wdata = 0, dm_pc = 0, dm_addr = 0, dm_wdata = 0;
  logic [4:0] grf_addr = 0;
  logic out_valid, out_kind, full, overflow;
  logic [31:0] out_pc, out_addr, out_data;
  logic [3:0] count;
`ifdef TRACE_TS_EN
  logic [31:0] out_time;
`endif
  wb_trace_collector #(.DEPTH(DEPTH), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
    .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
`ifdef TRACE_TS_EN
    .out_time(out_time),
`endif
    .count(count), .full(full), .overflow(overflow));
  always #5 clk = ~clk;
  typedef struct {
    logic kind;
    logic [31:0] pc, addr, data, ts;
  } rec_t;
  rec_t q[$];
  logic m_ovf = 0;
  logic [31:0] tcnt = 0;
  int pass_cnt = 0, total_cnt = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  task automatic model_clear();
    q.delete();
    m_ovf = 0;
    tcnt = 0;
  endtask
  task automatic model_update();
    int n, free;
    rec_t r;
    n = q.size();
    free = DEPTH - n;
    if (n > 0 && out_ready) void'(q.pop_front());
    if (grf_we && grf_addr != 0) begin
      if (free >= 1) begin
        r = '{1'b0, grf_pc, {27'b0, grf_addr}, grf_wdata, tcnt};
        q.push_back(r);
        free--;
      end else m_ovf = 1;
    end
    if (dm_we) begin
      if (free >= 1) begin
        r = '{1'b1, dm_pc, dm_addr, dm_wdata, tcnt};
        q.push_back(r);
      end else m_ovf = 1;
    end
    tcnt++;
  endtask
  task automatic compare_all();
    chk("valid", out_valid, q.size() != 0);
    chk("count", count, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    if (q.size() != 0) begin
      chk("kind", out_kind, q[0].kind);
      chk("pc", out_pc, q[0].pc);
      chk("addr", out_addr, q[0].addr);
      chk("data", out_data, q[0].data);
`ifdef TRACE_TS_EN
      chk("time", out_time, q[0].ts);
`endif
    end else begin
`ifdef TRACE_TS_EN
      chk("time_empty", out_time, 0);
`endif
      if (!reset) begin
        chk("rst_kind", out_kind, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_data", out_data, 0);
      end
    end
  endtask
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    if (reset) model_update();
    #1;
  endtask
  task automatic idle();
    grf_we = 0;
    dm_we = 0;
  endtask
  task automatic set_grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    grf_we = 1; grf_pc = pc; grf_addr = a; grf_wdata = d;
  endtask
  task automatic set_dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
    dm_we = 1; dm_pc = pc; dm_addr = a; dm_wdata = d;
  endtask
  task automatic do_reset();
    reset = 0;
    model_clear();
    tick();
    reset = 1;
  endtask
  logic [31:0] prev_t;
  initial begin
    model_clear();
    tick();
    tick();
    reset = 1;
    tick();
    // reset mid-stream
    for (int i = 0; i < 3; i++) begin
      set_grf(32'h3000 + 4 * i, 5'd1 + 5'(i), 32'h100 + i);
      tick();
    end
    idle();
    chk("t1_pre_count", count, 3);
    do_reset();
    chk("t1_count", count, 0);
    chk("t1_valid", out_valid, 0);
    chk("t1_ovf", overflow, 0);
    // single GRF
    set_grf(32'h3000, 5'd5, 32'h1234);
    tick();
    idle();
    chk("t2_valid", out_valid, 1);
    chk("t2_kind", out_kind, 0);
    chk("t2_addr", out_addr, 5);
    chk("t2_data", out_data, 32'h1234);
    chk("t2_pc", out_pc, 32'h3000);
    chk("t2_count", count, 1);
    out_ready = 1;
    tick();
    chk("t2_empty", out_valid, 0);
    out_ready = 0;
    // $0 filter
    set_grf(32'h3010, 5'd0, 32'hdead);
    for (int i = 0; i < 4; i++) tick();
    idle();
    chk("t3_count", count, 0);
    chk("t3_ovf", overflow, 0);
    // simultaneous events keep program order
    set_grf(32'h3004, 5'd8, 32'd7);
    set_dm(32'h3008, 32'h10, 32'hAB);
    tick();
    idle();
    chk("t4_count", count, 2);
    chk("t4_kind0", out_kind, 0);
    chk("t4_pc0", out_pc, 32'h3004);
    out_ready = 1;
    tick();
    chk("t4_kind1", out_kind, 1);
    chk("t4_pc1", out_pc, 32'h3008);
    chk("t4_addr1", out_addr, 32'h10);
    chk("t4_data1", out_data, 32'hAB);
    tick();
    chk("t4_empty", count, 0);
    out_ready = 0;
    // overflow
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_dm(32'h4000 + 4 * i, 32'h200 + 4 * i, i);
      tick();
    end
    chk("t5_count7", count, 7);
    set_grf(32'h5000, 5'd9, 32'h99);
    set_dm(32'h5004, 32'h300, 32'h77);
    tick();
    idle();
    chk("t5_count8", count, 8);
    chk("t5_model8", q.size(), 8);
    chk("t5_full", full, 1);
    chk("t5_ovf", overflow, 1);
    chk("t5_model_ovf", m_ovf, 1);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        chk("t5_last_kind", out_kind, 0);
        chk("t5_last_pc", out_pc, 32'h5000);
      end
      tick();
    end
    chk("t5_drained", count, 0);
    chk("t5_ovf_sticky", overflow, 1);
    // continuous push and pop across the pointer wrap
    do_reset();
    out_ready = 1;
    prev_t = 0;
    for (int i = 0; i < 20; i++) begin
      set_dm(32'h6000 + 4 * i, 32'h400 + 4 * i, 32'h1000 + i);
      tick();
      chk("t6_count", count, 1);
      chk("t6_data", out_data, 32'h1000 + i);
`ifdef TRACE_TS_EN
      if (i > 0) chk("t6_time_step", out_time, prev_t + 1);
      prev_t = out_time;
`endif
    end
    idle();
    out_ready = 0;
    // random traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      grf_we = ($urandom_range(0, 99) < 60);
      grf_addr = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31));
      grf_pc = $urandom;
      grf_wdata = $urandom;
      dm_we = ($urandom_range(0, 99) < 40);
      dm_pc = $urandom;
      dm_addr = $urandom;
      dm_wdata = $urandom;
      out_ready = ((i / 100) % 2 == 0) ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick();
    end
    idle();
    out_ready = 1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    chk("final_empty", count, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
